// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared element type, loader state encoding and counter sizing helper
//
// Purpose : common definitions for the dense-layer parameter loader slice.
// Contents: elem_t         default weight/bias element (8 bits)
//           load_state_e   loader FSM states
//           ctr_width(n)   index counter width, at least one bit
package mlp_pkg;

  typedef logic [7:0] elem_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } load_state_e;

  // Width needed to index 0..n-1, never narrower than one bit so that a
  // dimension of 1 still yields a legal (constant-zero) counter.
  function automatic int ctr_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dense_param_loader_if.sv
// rtl/dense_param_loader_if.sv - valid/ready word stream into the parameter loader
//
// Purpose : bundles the parameter word stream handshake.
// Signals : s_data   stream word (type T)
//           s_valid  producer has a word
//           s_ready  loader accepts the word this cycle
// Modports: master (producer), slave (loader)
interface dense_param_loader_if
  import mlp_pkg::*;
#(
  parameter type T = elem_t
) ();

  T     s_data;
  logic s_valid;
  logic s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/dense_param_idx_ctr.sv
// rtl/dense_param_idx_ctr.sv - wrap-around row/column index counter with terminal count
//
// Purpose : walks (row, col) in row-major order over ROWS x COLS, wrapping to
//           (0, 0) after the last position. A 1-D sequence uses ROWS = 1.
// Ports   : clk, rst  clock and synchronous active-high reset
//           clr       synchronous clear back to (0, 0)
//           en        advance one position
//           row, col  current position
//           last      current position is (ROWS-1, COLS-1)
module dense_param_idx_ctr
  import mlp_pkg::*;
#(
  parameter int ROWS = 1,
  parameter int COLS = 1,
  localparam int RW  = ctr_width(ROWS),
  localparam int CW  = ctr_width(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  logic row_last;
  logic col_last;

  assign col_last = (col == CW'(COLS - 1));
  assign row_last = (row == RW'(ROWS - 1));
  assign last     = row_last && col_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dense_param_loader.sv
// rtl/dense_param_loader.sv - streams dense-layer weights then biases into parallel flops
//
// Purpose : accepts weights in row-major [i][j] order followed by biases over a
//           valid/ready stream, holds them in flops and flags a complete set.
// Ports   : clk, rst      clock and synchronous active-high reset
//           load_start    pulse: restart loading, invalidates current set
//           s             stream slave (s_data, s_valid, s_ready)
//           weights       registered weights [D1][D2]
//           biases        registered biases [D2]
//           params_valid  complete set loaded and not invalidated
//           load_err      sticky checksum error (tied 0 unless checksum build)
// Build   : DENSE_PARAM_CHECKSUM_EN adds a trailing checksum word (modular sum
//           of all parameter words) that must match before params_valid rises.
module dense_param_loader
  import mlp_pkg::*;
#(
  parameter type T  = elem_t,
  parameter int  D1 = 4,
  parameter int  D2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  dense_param_loader_if.slave   s,
  output T                      weights [D1][D2],
  output T                      biases  [D2],
  output logic                  params_valid,
  output logic                  load_err
);

  localparam int WRW = ctr_width(D1);
  localparam int WCW = ctr_width(D2);
  localparam int BCW = ctr_width(D2);

  load_state_e    state;
  logic           ready_q;
  logic           beat;

  logic [WRW-1:0] w_row;
  logic [WCW-1:0] w_col;
  logic           w_last;
  logic           b_row_unused;
  logic [BCW-1:0] b_col;
  logic           b_last;

  // A restart cycle never consumes a word, even if the loader was ready.
  assign s.s_ready = ready_q && !load_start;
  assign beat      = s.s_valid && ready_q && !load_start;

  dense_param_idx_ctr #(
    .ROWS (D1),
    .COLS (D2)
  ) u_w_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_start),
    .en   (beat && (state == LOAD_W)),
    .row  (w_row),
    .col  (w_col),
    .last (w_last)
  );

  dense_param_idx_ctr #(
    .ROWS (1),
    .COLS (D2)
  ) u_b_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_start),
    .en   (beat && (state == LOAD_B)),
    .row  (b_row_unused),
    .col  (b_col),
    .last (b_last)
  );

`ifdef DENSE_PARAM_CHECKSUM_EN
  T sum;
`else
  assign load_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ready_q      <= 1'b0;
      params_valid <= 1'b0;
      for (int i = 0; i < D1; i++) begin
        for (int j = 0; j < D2; j++) begin
          weights[i][j] <= '0;
        end
      end
      for (int j = 0; j < D2; j++) begin
        biases[j] <= '0;
      end
`ifdef DENSE_PARAM_CHECKSUM_EN
      sum      <= '0;
      load_err <= 1'b0;
`endif
    end else if (load_start) begin
      // Stale array contents are left in place; only params_valid guards them.
      state        <= LOAD_W;
      ready_q      <= 1'b1;
      params_valid <= 1'b0;
`ifdef DENSE_PARAM_CHECKSUM_EN
      sum      <= '0;
      load_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          ready_q <= 1'b0;
        end
        LOAD_W: begin
          if (beat) begin
            weights[w_row][w_col] <= s.s_data;
`ifdef DENSE_PARAM_CHECKSUM_EN
            sum <= sum + s.s_data;
`endif
            if (w_last) begin
              state <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (beat) begin
            biases[b_col] <= s.s_data;
`ifdef DENSE_PARAM_CHECKSUM_EN
            sum <= sum + s.s_data;
            if (b_last) begin
              state <= CHECK;
            end
`else
            if (b_last) begin
              state        <= DONE;
              ready_q      <= 1'b0;
              params_valid <= 1'b1;
            end
`endif
          end
        end
`ifdef DENSE_PARAM_CHECKSUM_EN
        CHECK: begin
          if (beat) begin
            ready_q <= 1'b0;
            if (s.s_data == sum) begin
              state        <= DONE;
              params_valid <= 1'b1;
            end else begin
              state    <= IDLE;
              load_err <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dense_param_loader.md
Name: dense_param_loader

Overview:
Sequential writer that fills the weight and bias register arrays consumed by the combinational dense layer in the MLP datapath. It accepts a valid/ready word stream: weights first in row-major [i][j] order, then biases. It holds all parameters in flops and presents them in parallel. It flags when a complete, consistent parameter set is available, so the downstream layer only computes on fully loaded parameters.

Parameters:
- T, logic [7:0], element type of every weight/bias word (NBits = $bits(T))
- D1, 4, layer input dimension (weight rows), must be >= 1
- D2, 4, layer output dimension (weight columns and bias count), must be >= 1

Ports:
- clk  input  1  single clock
- rst  input  1  synchronous reset, active-high
- load_start  input  1  pulse: begin a new load; invalidates current parameters
- s_data  input  T  stream word
- s_valid  input  1  stream word valid
- s_ready  output  1  loader accepts word this cycle
- weights  output  T [D1][D2]  registered weights, indexed [i][j]
- biases  output  T [D2]  registered biases
- params_valid  output  1  high when a complete set is loaded and not invalidated
- load_err  output  1  sticky error; only driven under CHECKSUM_EN, otherwise tied 0

Behaviour:
- Reset (rst high at a clk edge): state IDLE; all weights and biases = '0; params_valid = 0; load_err = 0; counters = 0; s_ready = 0.
- Beat = s_valid && s_ready. Data is captured only on a beat.
- Stream producer must hold s_data/s_valid stable until the beat. The loader never drops an accepted word.
- States:
  - IDLE: s_ready = 0. load_start -> LOAD_W, clear counters, params_valid = 0, load_err = 0.
  - LOAD_W: s_ready = 1. Beat k writes weights[i][j], with i = k / D2 and j = k % D2. Implemented as j counter 0..D2-1 wrapping into i counter 0..D1-1. Beat at i = D1-1, j = D2-1 -> LOAD_B.
  - LOAD_B: s_ready = 1. Beat writes biases[b], b = 0..D2-1. Beat at b = D2-1 -> DONE (or CHECK under CHECKSUM_EN).
  - DONE: s_ready = 0. params_valid = 1 from the cycle after the final beat. load_start -> LOAD_W with params_valid = 0 the next cycle.
- load_start in any state restarts at LOAD_W.
  - s_ready is forced 0 in the cycle load_start is high, so no word is consumed that cycle.
  - Partially written arrays keep stale values until overwritten.
  - params_valid stays 0 until the new load completes.
- Latency: total beats = D1*D2 + D2, minimum one beat per cycle with no bubbles. params_valid rises exactly 1 cycle after the last beat.
- Outputs are plain flops, with no combinational path from s_data to weights/biases.
- rst mid-load: everything returns to reset values, including already-loaded words.
- Counter widths: $clog2 of dimension with a minimum of 1 bit. D1 = 1 or D2 = 1 must work.

Optional Feature:
Macro DENSE_PARAM_CHECKSUM_EN.
- Defined:
  - A running NBits-wide modular sum of all D1*D2 + D2 words is kept.
  - After LOAD_B, state CHECK accepts one extra word (s_ready = 1).
  - If that word equals the sum: DONE with params_valid = 1.
  - Otherwise: IDLE with load_err = 1 (sticky until load_start or rst) and params_valid = 0.
  - Beats per load = D1*D2 + D2 + 1.
- Undefined:
  - No CHECK state and no sum register.
  - load_err is tied 0.

Decomposition:
- Shared mlp_pkg holds:
  - default element typedef (logic [7:0])
  - state enum (IDLE, LOAD_W, LOAD_B, CHECK, DONE)
  - helper function for counter width (max(1, $clog2(n)))
- Natural sub-module: dense_param_idx_ctr, a wrap-around row/column index counter with terminal-count output, reused for the weight (2-D) and bias (1-D) sequences.
- The datapath stays in the top.

Test Plan:
- D1=2, D2=3, macro off:
  - Reset, pulse load_start, stream 1..9 with continuous valid -> weights = {{1,2,3},{4,5,6}}, biases = {7,8,9}.
  - params_valid = 1 exactly 1 cycle after word 9; s_ready = 0 afterwards.
- Backpressure from the source: toggle s_valid randomly over the same 9 words -> identical arrays; params_valid never asserts early.
- Restart: after 4 words, pulse load_start alongside s_valid=1, data=99 -> 99 is not consumed (s_ready = 0 that cycle). Restream 11..19 -> weights[0][0] = 11, biases[2] = 19.
- Reset mid-load: rst after 5 words -> all outputs 0, state IDLE, s_ready = 0; extra s_valid words are ignored until load_start.
- D1=1, D2=1: stream 5, 6 -> weights[0][0] = 5, biases[0] = 6, params_valid high after 2 beats.
- Macro on, D1=2, D2=3: words 1..9 then 45 -> params_valid = 1. Repeat with 44 -> load_err = 1, params_valid = 0, state IDLE; the next load_start clears load_err.
